// File: rtl/mux4_rr_sched_pkg.sv
// rtl/mux4_rr_sched_pkg.sv - shared types and helpers for the 4:1 selector scheduler
// Purpose : state encoding, channel count, pointer reset value and the
//           channel-to-select mapping of the downstream 4:1 selector.
// Ports   : none (package).
package mux4_pkg;

    localparam int NCH = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    // Pointer starts on channel 3 so channel 0 wins first after reset.
    localparam logic [1:0] LAST_RST = 2'd3;

    // The selector wires its legs in reverse: sel 00 picks d3, 11 picks d0.
    function automatic logic [1:0] ch_to_sel(input logic [1:0] ch);
        return ~ch;
    endfunction

endpackage

// File: rtl/mux4_rr_sched_if.sv
// rtl/mux4_rr_sched_if.sv - requester/selector/consumer bundle of the scheduler
// Purpose : groups the request, selector and output-port signals.
// Ports   : req, mux_out, out_ready  (into the scheduler)
//           sel, gnt, out_data, out_ch, out_valid (out of the scheduler)
//           modport slave = scheduler side, master = environment side.
interface mux4_rr_sched_if #(
    parameter int WIDTH = 2
);
    logic [3:0]       req;
    logic [WIDTH-1:0] mux_out;
    logic [1:0]       sel;
    logic [3:0]       gnt;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       out_ch;
    logic             out_valid;
    logic             out_ready;

    modport slave (
        input  req, mux_out, out_ready,
        output sel, gnt, out_data, out_ch, out_valid
    );

    modport master (
        output req, mux_out, out_ready,
        input  sel, gnt, out_data, out_ch, out_valid
    );
endinterface

// File: rtl/mux4_rr_sched_rr_pick4.sv
// rtl/mux4_rr_sched_rr_pick4.sv - combinational 4-way round-robin picker
// Purpose : picks the first requester after the last winner, wrapping mod 4.
// Ports   : i_req[3:0]  request vector
//           i_last[1:0] previous winner
//           o_any       at least one request present
//           o_win[1:0]  winning channel (0 when o_any is low)
module rr_pick4 (
    input  logic [3:0] i_req,
    input  logic [1:0] i_last,
    output logic       o_any,
    output logic [1:0] o_win
);
    logic       w_found;
    logic [1:0] w_idx;

    assign o_any = |i_req;

    // Scan last+1 .. last+4; the first hit wins, so last itself is checked last.
    always_comb begin
        o_win   = 2'd0;
        w_found = 1'b0;
        w_idx   = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            w_idx = i_last + 2'(k);
            if (!w_found && i_req[w_idx]) begin
                o_win   = w_idx;
                w_found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mux4_rr_sched.sv
// rtl/mux4_rr_sched.sv - round-robin scheduler driving a 4:1 two-bit selector
// Purpose : arbitrates four requesters, steers the selector, captures its
//           output one cycle later and offers it on a valid/ready port,
//           pulsing a one-cycle grant to the winner.
// Ports   : clk  clock, rising edge
//           rst  asynchronous active-high reset
//           bus  mux4_rr_sched_if.slave (req, mux_out, out_ready in;
//                sel, gnt, out_data, out_ch, out_valid out)
module mux4_rr_sched
    import mux4_pkg::*;
#(
    parameter int WIDTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    mux4_rr_sched_if.slave     bus
);
    state_t           r_state;
    state_t           w_next;
    logic [1:0]       r_sel;
    logic [1:0]       r_ch;
    logic [1:0]       r_last;
    logic [1:0]       r_out_ch;
    logic [NCH-1:0]   r_gnt;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_valid;
    logic             w_any;
    logic [1:0]       w_win;

    rr_pick4 u_pick (
        .i_req  (bus.req),
        .i_last (r_last),
        .o_any  (w_any),
        .o_win  (w_win)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_any) w_next = SAMPLE;
            SAMPLE:  w_next = HOLD;
            HOLD:    if (bus.out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel       <= 2'b00;
            r_ch        <= 2'd0;
            r_last      <= LAST_RST;
            r_gnt       <= '0;
            r_out_data  <= '0;
            r_out_ch    <= 2'd0;
            r_out_valid <= 1'b0;
        end else begin
            // Grant is a single-cycle pulse; only SAMPLE raises it.
            r_gnt <= '0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_sel <= ch_to_sel(w_win);
                        r_ch  <= w_win;
                    end
                end
                SAMPLE: begin
                    // sel was registered last edge, so mux_out has settled.
                    r_out_data   <= bus.mux_out;
                    r_out_ch     <= r_ch;
                    r_out_valid  <= 1'b1;
                    r_gnt[r_ch]  <= 1'b1;
                    r_last       <= r_ch;
                end
                HOLD: begin
                    if (bus.out_ready) r_out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.sel       = r_sel;
    assign bus.gnt       = r_gnt;
    assign bus.out_data  = r_out_data;
    assign bus.out_ch    = r_out_ch;
    assign bus.out_valid = r_out_valid;
endmodule

// File: tb/tb_mux4_rr_sched.sv
// tb/tb_mux4_rr_sched.sv - self-checking bench for mux4_rr_sched
module tb_mux4_rr_sched;

    typedef struct {
        logic [1:0] ch;
        logic [1:0] data;
    } exp_t;

    logic clk;
    logic rst;
    logic [1:0] d [4];
    logic [1:0] w_leg_idx;
    int checks;
    int errors;
    int cyc;
    exp_t exp_q [$];

    mux4_rr_sched_if #(.WIDTH(2)) bus ();

    mux4_rr_sched #(.WIDTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Selector model: sel 00 -> d3 ... 11 -> d0.
    assign w_leg_idx   = ~bus.sel;
    assign bus.mux_out = d[w_leg_idx];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic test_reset();
        rst = 1'b1;
        bus.req = 4'b0000;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) d[i] = 2'(i);
        repeat (2) @(negedge clk);
        checks++; if (bus.sel !== 2'b00) begin errors++; $display("FAIL reset_sel got %b want 00", bus.sel); end
        checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got %b want 0000", bus.gnt); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.out_data !== 2'b00 || bus.out_ch !== 2'd0) begin errors++; $display("FAIL reset_out got data %b ch %0d want 00/0", bus.out_data, bus.out_ch); end
        rst = 1'b0;
    endtask

    task automatic test_single();
        exp_t e;
        d[2] = 2'b10;
        bus.req = 4'b0100;
        bus.out_ready = 1'b1;
        exp_q.push_back('{ch: 2'd2, data: 2'b10});
        @(negedge clk);
        checks++; if (bus.sel !== 2'b01 || bus.out_valid !== 1'b0 || bus.gnt !== 4'b0000) begin errors++; $display("FAIL single_sample got sel %b valid %b gnt %b want 01/0/0000", bus.sel, bus.out_valid, bus.gnt); end
        @(negedge clk);
        e = exp_q.pop_front();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== e.data || bus.out_ch !== e.ch) begin errors++; $display("FAIL single_out got v %b data %b ch %0d want 1/%b/%0d", bus.out_valid, bus.out_data, bus.out_ch, e.data, e.ch); end
        checks++; if (bus.gnt !== 4'b0100) begin errors++; $display("FAIL single_gnt got %b want 0100", bus.gnt); end
        bus.req = 4'b0000;
        @(negedge clk);
        checks++; if (bus.gnt !== 4'b0000 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_after got gnt %b valid %b want 0000/0", bus.gnt, bus.out_valid); end
    endtask

    task automatic test_round_robin();
        exp_t e;
        int last_cyc;
        int n;
        logic [1:0] want_sel;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) d[i] = 2'(i);
        for (int i = 0; i < 5; i++) exp_q.push_back('{ch: 2'(i % 4), data: 2'(i % 4)});
        bus.out_ready = 1'b1;
        bus.req = 4'b1111;
        last_cyc = -1;
        n = 0;
        for (int t = 0; t < 40 && exp_q.size() > 0; t++) begin
            @(negedge clk);
            if (bus.gnt !== 4'b0000) begin
                e = exp_q.pop_front();
                want_sel = ~e.ch;
                checks++; if (bus.out_ch !== e.ch || bus.out_data !== e.data) begin errors++; $display("FAIL rr_word%0d got ch %0d data %b want %0d/%b", n, bus.out_ch, bus.out_data, e.ch, e.data); end
                checks++; if (bus.gnt !== (4'b0001 << e.ch) || bus.sel !== want_sel) begin errors++; $display("FAIL rr_gnt_sel%0d got gnt %b sel %b want ch %0d sel %b", n, bus.gnt, bus.sel, e.ch, want_sel); end
                if (last_cyc >= 0) begin
                    checks++; if (cyc - last_cyc !== 3) begin errors++; $display("FAIL rr_spacing%0d got %0d want 3", n, cyc - last_cyc); end
                end
                last_cyc = cyc;
                n++;
            end
        end
        bus.req = 4'b0000;
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rr_timeout got %0d pending want 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_pointer_wrap();
        exp_t e;
        exp_q.push_back('{ch: 2'd3, data: 2'd3});
        bus.req = 4'b1000;
        for (int ph = 0; ph < 2; ph++) begin
            for (int t = 0; t < 30 && exp_q.size() > 0; t++) begin
                @(negedge clk);
                if (bus.gnt !== 4'b0000) begin
                    e = exp_q.pop_front();
                    checks++; if (bus.out_ch !== e.ch || bus.gnt !== (4'b0001 << e.ch)) begin errors++; $display("FAIL wrap_ph%0d got ch %0d gnt %b want %0d", ph, bus.out_ch, bus.gnt, e.ch); end
                end
            end
            if (ph == 0) begin
                bus.req = 4'b1001;
                exp_q.push_back('{ch: 2'd0, data: 2'd0});
                exp_q.push_back('{ch: 2'd3, data: 2'd3});
            end
        end
        bus.req = 4'b0000;
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_timeout got %0d pending want 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_backpressure();
        exp_t e;
        bit seen;
        @(negedge clk);
        d[1] = 2'b01;
        bus.out_ready = 1'b0;
        bus.req = 4'b0010;
        exp_q.push_back('{ch: 2'd1, data: 2'b01});
        seen = 0;
        for (int t = 0; t < 10 && !seen; t++) begin
            @(negedge clk);
            if (bus.gnt !== 4'b0000) seen = 1;
        end
        checks++; if (!seen) begin errors++; $display("FAIL bp_timeout got no gnt want 0010"); end
        e = exp_q.pop_front();
        for (int t = 0; t < 5; t++) begin
            if (t > 0) @(negedge clk);
            checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== e.data || bus.out_ch !== e.ch || bus.sel !== 2'b10) begin errors++; $display("FAIL bp_hold%0d got v %b data %b ch %0d sel %b want 1/%b/%0d/10", t, bus.out_valid, bus.out_data, bus.out_ch, bus.sel, e.data, e.ch); end
            checks++; if (bus.gnt !== ((t == 0) ? 4'b0010 : 4'b0000)) begin errors++; $display("FAIL bp_gnt%0d got %b", t, bus.gnt); end
        end
        bus.out_ready = 1'b1;
        bus.req = 4'b0000;
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_release got valid %b want 0", bus.out_valid); end
    endtask

    task automatic test_early_drop();
        exp_t e;
        bit seen;
        d[2] = 2'b10;
        bus.req = 4'b0100;
        exp_q.push_back('{ch: 2'd2, data: 2'b10});
        @(negedge clk);
        checks++; if (bus.sel !== 2'b01) begin errors++; $display("FAIL drop_sel got %b want 01", bus.sel); end
        bus.req = 4'b0000;
        seen = 0;
        for (int t = 0; t < 5 && !seen; t++) begin
            @(negedge clk);
            if (bus.gnt !== 4'b0000) begin
                seen = 1;
                e = exp_q.pop_front();
                checks++; if (bus.gnt !== 4'b0100 || bus.out_data !== e.data || bus.out_ch !== e.ch) begin errors++; $display("FAIL drop_out got gnt %b data %b ch %0d want 0100/%b/%0d", bus.gnt, bus.out_data, bus.out_ch, e.data, e.ch); end
            end
        end
        checks++; if (!seen) begin errors++; $display("FAIL drop_timeout got no gnt want 0100"); exp_q.delete(); end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        exp_t e;
        bit seen;
        bus.out_ready = 1'b0;
        bus.req = 4'b0001;
        seen = 0;
        for (int t = 0; t < 10 && !seen; t++) begin
            @(negedge clk);
            if (bus.gnt !== 4'b0000) seen = 1;
        end
        bus.req = 4'b0000;
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b1 || bus.sel !== 2'b11) begin errors++; $display("FAIL ar_hold got v %b sel %b want 1/11", bus.out_valid, bus.sel); end
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.gnt !== 4'b0000 || bus.sel !== 2'b00) begin errors++; $display("FAIL ar_async got v %b gnt %b sel %b want 0/0000/00", bus.out_valid, bus.gnt, bus.sel); end
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        bus.req = 4'b1111;
        exp_q.push_back('{ch: 2'd0, data: 2'd0});
        seen = 0;
        for (int t = 0; t < 10 && !seen; t++) begin
            @(negedge clk);
            if (bus.gnt !== 4'b0000) begin
                seen = 1;
                e = exp_q.pop_front();
                checks++; if (bus.out_ch !== e.ch || bus.gnt !== 4'b0001 || bus.out_data !== e.data) begin errors++; $display("FAIL ar_first got ch %0d gnt %b data %b want 0/0001/00", bus.out_ch, bus.gnt, bus.out_data); end
            end
        end
        bus.req = 4'b0000;
        checks++; if (!seen) begin errors++; $display("FAIL ar_timeout got no gnt want 0001"); exp_q.delete(); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_pointer_wrap();
        test_backpressure();
        test_early_drop();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
